// File: rtl/md5_chunk_engine.sv
// MD5 compression engine: one 512-bit chunk per handshake, chained over multi-chunk messages.
// Optional target comparator (target/match ports) is built when MD5_TARGET_MATCH_EN is defined.
module md5_chunk_engine #(
  parameter logic [31:0] INITA  = 32'h67452301,
  parameter logic [31:0] INITB  = 32'hefcdab89,
  parameter logic [31:0] INITC  = 32'h98badcfe,
  parameter logic [31:0] INITD  = 32'h10325476,
  parameter int          ROUNDS = 64,
  parameter int          SLOW   = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_digest,
  output logic         busy
`ifdef MD5_TARGET_MATCH_EN
  ,
  input  logic [127:0] target,
  output logic         match
`endif
);

  // state  | meaning
  // IDLE   | waiting for a chunk, in_ready=1
  // CRUNCH | running steps 0..ROUNDS-1 on the latched chunk
  // FINAL  | fold working regs into chaining regs a0..d0
  // OUT    | digest presented until out_ready
  typedef enum logic [1:0] {IDLE, CRUNCH, FINAL, OUT} state_t;

  localparam logic [5:0] LAST_STEP = 6'(ROUNDS - 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amounts repeat every four steps within a round: indexed by {round, i[1:0]}.
  localparam logic [4:0] S_ROM [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  state_t state, state_nxt;

  logic [511:0] blk;
  logic         last;
  logic [5:0]   i;
  logic         phase;
  logic [31:0]  a, b, c, d;
  logic [31:0]  a0, b0, c0, d0;
  logic [31:0]  sum_q;

  logic [31:0]  f, m, sum, rot_in, rot;
  logic [63:0]  rot_dbl;
  logic [3:0]   g;
  logic [4:0]   s;
  logic         step_en, done_step, accept;

  always_comb begin
    f = '0;
    g = '0;
    unique case (i[5:4])
      2'd0: begin f = (b & c) | (~b & d); g = i[3:0];                end
      2'd1: begin f = (d & b) | (~d & c); g = i[3:0] * 4'd5 + 4'd1; end
      2'd2: begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5; end
      2'd3: begin f = c ^ (b | ~d);       g = i[3:0] * 4'd7;        end
    endcase
  end

  assign m       = blk[32*g +: 32];
  assign s       = S_ROM[{i[5:4], i[1:0]}];
  assign sum     = a + f + K_ROM[i] + m;
  // In the two-cycle mode the rotate-add consumes the registered sum.
  assign rot_in  = (SLOW != 0) ? sum_q : sum;
  assign rot_dbl = {rot_in, rot_in} << s;
  assign rot     = rot_dbl[63:32];

  assign step_en    = (state == CRUNCH) && ((SLOW == 0) || phase);
  assign done_step  = step_en && (i == LAST_STEP);
  assign accept     = (state == IDLE) && in_valid;
  assign out_digest = {d0, c0, b0, a0};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = CRUNCH;
      end
      CRUNCH: if (done_step) state_nxt = FINAL;
      FINAL:  state_nxt = last ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a0    <= INITA;
      b0    <= INITB;
      c0    <= INITC;
      d0    <= INITD;
      i     <= '0;
      phase <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          i     <= '0;
          phase <= 1'b0;
        end
        CRUNCH: begin
          if (step_en) begin
            i     <= i + 6'd1;
            phase <= 1'b0;
          end else begin
            phase <= 1'b1;
          end
        end
        FINAL: begin
          a0 <= a0 + a;
          b0 <= b0 + b;
          c0 <= c0 + c;
          d0 <= d0 + d;
        end
        OUT: if (out_ready) begin
          a0 <= INITA;
          b0 <= INITB;
          c0 <= INITC;
          d0 <= INITD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      blk  <= in_block;
      last <= in_last;
      a    <= a0;
      b    <= b0;
      c    <= c0;
      d    <= d0;
    end else if (step_en) begin
      a <= d;
      b <= b + rot;
      c <= b;
      d <= c;
    end
    if ((state == CRUNCH) && !step_en) sum_q <= sum;
  end

`ifdef MD5_TARGET_MATCH_EN
  always_ff @(posedge clk) begin
    if (reset)
      match <= 1'b0;
    else if ((state == FINAL) && last)
      match <= ({d0 + d, c0 + c, b0 + b, a0 + a} == target);
    else if ((state == OUT) && out_ready)
      match <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_md5_chunk_engine.sv
// Directed bench for md5_chunk_engine: default, SLOW=1 and ROUNDS=16 instances.
// Exercises the target comparator too when MD5_TARGET_MATCH_EN is defined.
module tb_md5_chunk_engine;

  localparam logic [127:0] DIG_EMPTY = 128'h7e42f8ec980980e904b2008fd98c1dd4;
  localparam logic [127:0] DIG_ABC   = 128'h727fe1287d3f96d6b04fd23c98500190;
  localparam logic [127:0] DIG_80    = 128'h7ab607212eda49ac55c9e32ba2f4ed57;

  localparam logic [31:0] KT [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int ST [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] in_block;
  logic         in_last;
  logic [2:0]   vld, ordy;
  logic [2:0]   irdy, ovld, bsy;
  logic [127:0] dig [3];
`ifdef MD5_TARGET_MATCH_EN
  logic [127:0] target;
  logic [2:0]   mt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  md5_chunk_engine dut (
    .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(irdy[0]), .in_block(in_block),
    .in_last(in_last), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_digest(dig[0]), .busy(bsy[0])
`ifdef MD5_TARGET_MATCH_EN
    , .target(target), .match(mt[0])
`endif
  );

  md5_chunk_engine #(.SLOW(1)) dut_slow (
    .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(irdy[1]), .in_block(in_block),
    .in_last(in_last), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_digest(dig[1]), .busy(bsy[1])
`ifdef MD5_TARGET_MATCH_EN
    , .target(target), .match(mt[1])
`endif
  );

  md5_chunk_engine #(.ROUNDS(16)) dut_r16 (
    .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(irdy[2]), .in_block(in_block),
    .in_last(in_last), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_digest(dig[2]), .busy(bsy[2])
`ifdef MD5_TARGET_MATCH_EN
    , .target(target), .match(mt[2])
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single-chunk reference from the standard IV, truncated to the given step count.
  function automatic logic [127:0] md5_model(input logic [511:0] blk, input int rounds);
    logic [31:0] a, b, c, d, f, t;
    int g, sh;
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int j = 0; j < rounds; j++) begin
      case (j / 16)
        0:       begin f = (b & c) | (~b & d); g = j;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * j + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * j + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * j) % 16;     end
      endcase
      t  = a + f + KT[j] + blk[32*g +: 32];
      sh = ST[(j / 16) * 4 + j % 4];
      t  = (t << sh) | (t >> (32 - sh));
      a = d; d = c; c = b; b = b + t;
    end
    return {d + 32'h10325476, c + 32'h98badcfe, b + 32'hefcdab89, a + 32'h67452301};
  endfunction

  task automatic send(input int u, input string tag, input logic [511:0] blk, input logic lst);
    int t;
    in_block = blk;
    in_last  = lst;
    vld[u]   = 1'b1;
    t = 0;
    while (!irdy[u] && t < 400) begin @(posedge clk); #1; t++; end
    check({tag, "_ready"}, irdy[u], 1'b1);
    @(posedge clk); #1;
    vld[u] = 1'b0;
  endtask

  task automatic wait_out(input int u, input string tag, output int lat);
    lat = 0;
    while (!ovld[u] && lat < 400) begin @(posedge clk); #1; lat++; end
    check({tag, "_ovld"}, ovld[u], 1'b1);
  endtask

  task automatic take(input int u, input string tag);
    ordy[u] = 1'b1;
    @(posedge clk); #1;
    ordy[u] = 1'b0;
    check({tag, "_ovld_fall"}, ovld[u], 1'b0);
    check({tag, "_irdy_rise"}, irdy[u], 1'b1);
  endtask

  initial begin
    logic [511:0] b_empty, b_abc, c1, c2;
    logic [127:0] held;
    int lat, n;
    logic bad, seen;

    b_empty = '0; b_empty[31:0] = 32'h00000080;
    b_abc   = '0; b_abc[31:0] = 32'h80636261; b_abc[14*32 +: 32] = 32'd24;
    c1 = '0; c2 = '0;
    for (int k = 0; k < 64; k++) c1[8*k +: 8] = 8'h30 + 8'((k + 1) % 10);
    for (int k = 0; k < 16; k++) c2[8*k +: 8] = 8'h30 + 8'((k + 65) % 10);
    c2[8*16 +: 8] = 8'h80;
    c2[14*32 +: 32] = 32'd640;

    vld = '0; ordy = '0; in_block = '0; in_last = 1'b0; reset = 1'b1;
`ifdef MD5_TARGET_MATCH_EN
    target = '0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_irdy", irdy, 3'b111);
    check("reset_ovld", ovld, 3'b000);
    check("reset_busy", bsy, 3'b000);

    send(0, "empty", b_empty, 1'b1);
    check("empty_busy", bsy[0], 1'b1);
    wait_out(0, "empty", lat);
    check("empty_lat", lat, 65);
    check("empty_dig", dig[0], DIG_EMPTY);
    take(0, "empty");

    send(0, "abc", b_abc, 1'b1);
    wait_out(0, "abc", lat);
    check("abc_lat", lat, 65);
    check("abc_dig", dig[0], DIG_ABC);
    held = dig[0];
    bad = 1'b0;
    vld[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (dig[0] !== held || irdy[0] !== 1'b0 || ovld[0] !== 1'b1) bad = 1'b1;
    end
    vld[0] = 1'b0;
    check("abc_hold_stable", bad, 1'b0);
    check("abc_hold_dig", dig[0], DIG_ABC);
    take(0, "abc");

    send(0, "two_c1", c1, 1'b0);
    n = 0; seen = 1'b0;
    while (!irdy[0] && n < 400) begin
      @(posedge clk); #1; n++;
      if (ovld[0]) seen = 1'b1;
    end
    check("two_c1_irdy_lat", n, 65);
    check("two_c1_no_ovld", seen, 1'b0);
    send(0, "two_c2", c2, 1'b1);
    wait_out(0, "two_c2", lat);
    check("two_c2_lat", lat, 65);
    check("two_dig", dig[0], DIG_80);
    take(0, "two");

    send(0, "rst_c1", c1, 1'b0);
    n = 0;
    while (!irdy[0] && n < 400) begin @(posedge clk); #1; n++; end
    send(0, "rst_c2", c2, 1'b1);
    repeat (29) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_irdy", irdy[0], 1'b1);
    check("rst_ovld", ovld[0], 1'b0);
    check("rst_busy", bsy[0], 1'b0);
    send(0, "rst_abc", b_abc, 1'b1);
    wait_out(0, "rst_abc", lat);
    check("rst_abc_dig", dig[0], DIG_ABC);
    take(0, "rst_abc");

    send(1, "slow", b_empty, 1'b1);
    wait_out(1, "slow", lat);
    check("slow_lat", lat, 129);
    check("slow_dig", dig[1], DIG_EMPTY);
    take(1, "slow");

    send(2, "r16", b_empty, 1'b1);
    wait_out(2, "r16", lat);
    check("r16_lat", lat, 17);
    check("r16_dig", dig[2], md5_model(b_empty, 16));
    take(2, "r16");

`ifdef MD5_TARGET_MATCH_EN
    target = DIG_ABC;
    send(0, "m_hit", b_abc, 1'b1);
    wait_out(0, "m_hit", lat);
    check("m_hit_match", mt[0], 1'b1);
    take(0, "m_hit");
    check("m_hit_clear", mt[0], 1'b0);
    target = DIG_ABC ^ 128'h1;
    send(0, "m_miss", b_abc, 1'b1);
    wait_out(0, "m_miss", lat);
    check("m_miss_match", mt[0], 1'b0);
    take(0, "m_miss");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md5_chunk_engine.md
# md5_chunk_engine

Parametrised MD5 compression engine: the successor to the fixed 4-cycle-per-step chunk cruncher. It accepts whole 512-bit chunks over a valid/ready handshake and holds the K/S constants and message schedule internally. Multi-chunk messages are chained automatically, and the throughput/area trade-off is set by a parameter. It sits between the candidate generator (padded blocks in) and the digest comparator (digests out) in the compute lane.

## Interface
- INITA, default 32'h67452301: IV word A; INITB/INITC/INITD default efcdab89/98badcfe/10325476.
- ROUNDS, default 64: steps executed per chunk. Legal values are 16, 32, 48, 64. Values below 64 are reduced-round modes for test and bring-up only.
- SLOW, default 0: 0 = one MD5 step per cycle; 1 = two cycles per step, with `a+f+K+M` registered before the rotate-add.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  chunk offered.
- in_ready  out  1  engine idle; chunk accepted on `in_valid & in_ready`.
- in_block  in  512  chunk. Word g = `in_block[32g+31:32g]`.
- in_last  in  1  accepted chunk is the final chunk of its message.
- out_valid  out  1  digest available.
- out_ready  in  1  consumer takes digest on `out_valid & out_ready`.
- out_digest  out  128  `{d0,c0,b0,a0}`.
- busy  out  1  state != IDLE.
- target  in  128  comparison digest. Present only with MD5_TARGET_MATCH_EN.
- match  out  1  digest equals target. Present only with MD5_TARGET_MATCH_EN.

## Operation
- States: IDLE, CRUNCH, FINAL, OUT.
- IDLE: `in_ready`=1. On accept, latch in_block and in_last. Load working regs a/b/c/d from chaining regs a0..d0. Clear step counter i. Go to CRUNCH.
- CRUNCH: step i uses the standard MD5 f/g selection by `i[5:4]`, plus the internal K[i] and S[i] ROMs.
  - Update: `b' = b + rotl(a+f+K[i]+M[g], S[i])`, `a'=d`, `c'=b`, `d'=c`.
  - All arithmetic is mod 2^32.
  - After step ROUNDS-1, go to FINAL.
- FINAL: one cycle. `a0+=a`, `b0+=b`, `c0+=c`, `d0+=d` in parallel.
  - If the latched in_last=1, go to OUT.
  - Otherwise go to IDLE and keep the chained a0..d0 for the next chunk.
- OUT: hold `out_valid`=1 with out_digest stable until `out_ready`.
  - On handshake, reload a0..d0 with the IV and go to IDLE.
  - No chunk is accepted in OUT.
- out_digest always reflects a0..d0. It is only meaningful while out_valid=1.
- Reset, in any state including mid-CRUNCH or OUT:
  - state becomes IDLE; a0..d0 reload to the IV; the partial chunk is discarded.
  - out_valid=0; busy=0; match=0.
  - in_ready=1 from the first cycle after reset deasserts.
- A chunk offered while not IDLE is ignored; the source must hold it.

## Timing
- Accept edge = cycle 0.
- CRUNCH lasts `ROUNDS*(SLOW+1)` cycles. FINAL lasts 1 cycle.
- For a last chunk, out_valid rises `ROUNDS*(SLOW+1)+1` cycles after accept:
  - 65 cycles for the default parameters.
  - 129 cycles with SLOW=1.
- For a non-last chunk, in_ready returns after the same count.
- Back-to-back chunks of one message: a new chunk can be accepted every `ROUNDS*(SLOW+1)+2` cycles.
- out_valid falls the cycle after the out_valid & out_ready handshake. in_ready rises in that same cycle.
- Critical path is set by SLOW: SLOW=0 chains f, a 4-input add, the rotate and an add in one cycle; SLOW=1 splits this at the register.

## Configuration
- MD5_TARGET_MATCH_EN defined:
  - Adds the target and match ports.
  - match is registered. It is set in the FINAL cycle of a last chunk, equal to (new digest == target), and is valid together with out_valid.
  - It is cleared on the output handshake and on reset.
- MD5_TARGET_MATCH_EN undefined: no target/match ports and no comparator logic. All other behaviour is identical.

## Test plan
- Empty message: in_block word0 = 32'h00000080, all other words 0, in_last=1, defaults. Required: out_valid at cycle 65 and out_digest = 128'h7e42f8ec980980e904b2008fd98c1dd4.
- "abc": word0 = 32'h80636261, word14 = 32'd24, in_last=1. Required: out_digest = 128'h727fe1287d3f96d6b04fd23c98500190. Then hold out_ready=0 for 10 cycles; digest must stay stable and in_ready=0 throughout.
- Two-chunk message (in_last=0, then 1): the second chunk must chain from the first. Required: digest matches the software model, out_valid pulses only after chunk 2, and in_ready reasserts 65 cycles after the chunk-1 accept.
- Assert reset at CRUNCH cycle 30, then send the "abc" block. Required: the "abc" digest above, proving the IV was restored.
- SLOW=1 and ROUNDS=16 builds with the empty-message block. Required: out_valid at cycles 129 and 17 respectively, and digests match the reduced-round model.
- With MD5_TARGET_MATCH_EN, "abc" block: target equal to the "abc" digest gives match=1; target with one bit flipped gives match=0; match clears after the output handshake.
